// File: rtl/instr_encoder_pkg.sv
// Shared types for the RV32I instruction encoder: opcodes, funct3 codes, FSM states
// and the immediate range limits used by the field packer.
package instr_encoder_pkg;

    typedef enum logic [6:0] {
        LUI    = 7'b0110111,
        AUIPC  = 7'b0010111,
        JAL    = 7'b1101111,
        JALR   = 7'b1100111,
        B_type = 7'b1100011,
        Load   = 7'b0000011,
        Store  = 7'b0100011,
        I_type = 7'b0010011,
        R_type = 7'b0110011
    } opcode_type_e;

    typedef enum logic [2:0] {
        F3_ADD  = 3'b000,
        F3_SLL  = 3'b001,
        F3_SLT  = 3'b010,
        F3_SLTU = 3'b011,
        F3_XOR  = 3'b100,
        F3_SR   = 3'b101,
        F3_OR   = 3'b110,
        F3_AND  = 3'b111
    } funct3_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EMIT  = 2'd1,
        EMIT2 = 2'd2,
        FULL  = 2'd3
    } state_e;

    localparam int          IMM12_MIN = -2048;
    localparam int          IMM12_MAX = 2047;
    localparam int unsigned SHAMT_MAX = 31;

    // True when v, read as a signed value, fits in a two's-complement field of 'bits' bits.
    function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
        logic signed [31:0] sh;
        sh = $signed(v) >>> (bits - 1);
        return (sh == 32'sd0) || (sh == -32'sd1);
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Request bus from the loader and the IMEM write port of the instruction encoder.
interface instr_encoder_if #(
    parameter int ADDR_W = 10
);
    logic              req_valid_i;
    logic              req_ready_o;
    logic [6:0]        opcode_i;
    logic [2:0]        funct3_i;
    logic [6:0]        funct7_i;
    logic [4:0]        rd_i;
    logic [4:0]        rs1_i;
    logic [4:0]        rs2_i;
    logic [31:0]       imm_i;
    logic              wr_en_o;
    logic              wr_ready_i;
    logic [ADDR_W-1:0] wr_addr_o;
    logic [31:0]       wr_data_o;

    modport master (
        output req_valid_i, opcode_i, funct3_i, funct7_i, rd_i, rs1_i, rs2_i, imm_i, wr_ready_i,
        input  req_ready_o, wr_en_o, wr_addr_o, wr_data_o
    );

    modport slave (
        input  req_valid_i, opcode_i, funct3_i, funct7_i, rd_i, rs1_i, rs2_i, imm_i, wr_ready_i,
        output req_ready_o, wr_en_o, wr_addr_o, wr_data_o
    );

endinterface

// File: rtl/instr_encoder_pack.sv
// Combinational field packer: instruction fields plus immediate -> encoded word(s),
// a range-violation flag and whether an li expansion needs a second ADDI word.
module instr_encoder_pack
    import instr_encoder_pkg::*;
(
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic [31:0] word2,
    output logic        err,
    output logic        needs_li
);

    logic        in12;
    logic [31:0] hi;

    assign in12 = ($signed(imm) >= IMM12_MIN) && ($signed(imm) <= IMM12_MAX);
    // Rounding bias so the sign-extended ADDI low part lands back on imm.
    assign hi   = imm + 32'h0000_0800;

    always_comb begin
        word     = '0;
        word2    = '0;
        err      = 1'b0;
        needs_li = 1'b0;
        case (opcode)
            LUI, AUIPC: begin
                err  = (imm[11:0] != 12'h000);
                word = {imm[31:12], rd, opcode};
            end
            JAL: begin
                err  = !fits_signed(imm, 21) || imm[0];
                word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            end
            JALR, Load: begin
                err  = !in12;
                word = {imm[11:0], rs1, funct3, rd, opcode};
            end
            I_type: begin
                if (funct3 == F3_SLL || funct3 == F3_SR) begin
                    err  = (imm > SHAMT_MAX);
                    word = {funct7, imm[4:0], rs1, funct3, rd, opcode};
                end else if (funct3 == F3_ADD && rs1 == 5'd0 && !in12) begin
                    word     = {hi[31:12], rd, LUI};
                    word2    = {imm[11:0], rd, F3_ADD, rd, I_type};
                    needs_li = (imm[11:0] != 12'h000);
                end else begin
                    err  = !in12;
                    word = {imm[11:0], rs1, funct3, rd, opcode};
                end
            end
            Store: begin
                err  = !in12;
                word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            end
            B_type: begin
                err  = !fits_signed(imm, 13) || imm[0];
                word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            end
            R_type: begin
                word = {funct7, rs2, rs1, funct3, rd, opcode};
            end
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder top: accepts field requests, streams encoded words into IMEM
// at an auto-incrementing word address and tracks how many words have been committed.
//
//  state | meaning
//  IDLE  | ready for a request (unless full)
//  EMIT  | first/only word presented on the write port
//  EMIT2 | second word of an li expansion presented
//  FULL  | capacity reached, requests refused until start/reset
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    instr_encoder_if.slave  bus,
    output logic            err_o,
    output logic            full_o,
    output logic [ADDR_W:0] count_o
);

    localparam logic [ADDR_W:0]   CAP       = (ADDR_W + 1)'(1) << ADDR_W;
    localparam logic [ADDR_W:0]   LAST_SLOT = CAP - (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);

    state_e            state_q, state_nxt;
    logic              wr_en_q, wr_en_nxt;
    logic              err_q, err_nxt;
    logic              pend2_q;
    logic [31:0]       word2_q;
    logic [31:0]       data_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   count_q, count_inc;
    logic              accept, reject;
    logic              ld_first, ld_second, advance;
    logic [31:0]       pk_word, pk_word2;
    logic              pk_err, pk_needs_li;

    instr_encoder_pack u_pack (
        .opcode   (bus.opcode_i),
        .funct3   (bus.funct3_i),
        .funct7   (bus.funct7_i),
        .rd       (bus.rd_i),
        .rs1      (bus.rs1_i),
        .rs2      (bus.rs2_i),
        .imm      (bus.imm_i),
        .word     (pk_word),
        .word2    (pk_word2),
        .err      (pk_err),
        .needs_li (pk_needs_li)
    );

    assign bus.req_ready_o = (state_q == IDLE) && !start_i;
    assign accept          = bus.req_valid_i && bus.req_ready_o;
    // A two-word li must fit entirely or not be written at all.
    assign reject          = pk_err || (pk_needs_li && (count_q == LAST_SLOT));
    assign count_inc       = count_q + (ADDR_W + 1)'(1);

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        wr_en_nxt = wr_en_q;
        err_nxt   = 1'b0;
        ld_first  = 1'b0;
        ld_second = 1'b0;
        advance   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (reject) begin
                        err_nxt = 1'b1;
                    end else begin
                        ld_first  = 1'b1;
                        wr_en_nxt = 1'b1;
                        state_nxt = EMIT;
                    end
                end
            end
            EMIT: begin
                if (bus.wr_ready_i) begin
                    advance = 1'b1;
                    if (pend2_q) begin
                        ld_second = 1'b1;
                        state_nxt = EMIT2;
                    end else begin
                        wr_en_nxt = 1'b0;
                        state_nxt = (count_inc == CAP) ? FULL : IDLE;
                    end
                end
            end
            EMIT2: begin
                if (bus.wr_ready_i) begin
                    advance   = 1'b1;
                    wr_en_nxt = 1'b0;
                    state_nxt = (count_inc == CAP) ? FULL : IDLE;
                end
            end
            FULL:    state_nxt = FULL;
            default: state_nxt = IDLE;
        endcase
        if (start_i) begin
            state_nxt = IDLE;
            wr_en_nxt = 1'b0;
            err_nxt   = 1'b0;
            ld_first  = 1'b0;
            ld_second = 1'b0;
            advance   = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_en_q <= 1'b0;
            err_q   <= 1'b0;
            pend2_q <= 1'b0;
            word2_q <= '0;
            data_q  <= '0;
            addr_q  <= BASE;
            count_q <= '0;
        end else begin
            wr_en_q <= wr_en_nxt;
            err_q   <= err_nxt;
            if (start_i) begin
                pend2_q <= 1'b0;
                addr_q  <= BASE;
                count_q <= '0;
            end else begin
                if (ld_first) begin
                    data_q  <= pk_word;
                    word2_q <= pk_word2;
                    pend2_q <= pk_needs_li;
                end
                if (ld_second) begin
                    data_q  <= word2_q;
                    pend2_q <= 1'b0;
                end
                if (advance) begin
                    addr_q  <= addr_q + ADDR_W'(1);
                    count_q <= count_inc;
                end
            end
        end
    end

    assign bus.wr_en_o   = wr_en_q;
    assign bus.wr_addr_o = addr_q;
    assign bus.wr_data_o = data_q;
    assign err_o         = err_q;
    assign full_o        = (count_q == CAP);
    assign count_o       = count_q;

endmodule
